// File: rtl/mem_block_arbiter.sv
// Purpose: arbitrates I-cache and D-cache block transfers onto one block memory port; `ROUND_ROBIN_EN alternates priority, otherwise D-cache wins.
// Latency: the strobe rises the cycle after the grant edge, and done pulses the cycle after mem valid or timeout; one RELEASE cycle follows.
// Backpressure: a requester that loses, or arrives while busy, keeps its level request high and is served from IDLE; no request is dropped.
module mem_block_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_req_i,
    input  logic [31:0]  i_addr_i,
    output logic [255:0] i_rdata_o,
    output logic         i_done_o,
    input  logic         d_req_i,
    input  logic         d_we_i,
    input  logic [31:0]  d_addr_i,
    input  logic [255:0] d_wdata_i,
    output logic [255:0] d_rdata_o,
    output logic         d_done_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_blk_read_o,
    output logic         mem_blk_write_o,
    output logic [255:0] mem_wdata_o,
    input  logic [255:0] mem_rdata_i,
    input  logic         mem_read_valid_i,
    input  logic         mem_write_valid_i,
    output logic         xfer_err_o,
    output logic         busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_I  = 3'd1,
        ST_BUSY_DR = 3'd2,
        ST_BUSY_DW = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   wdata_q, wdata_d;
    logic [255:0]   i_rdata_q, i_rdata_d;
    logic [255:0]   d_rdata_q, d_rdata_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           i_done_q, i_done_d;
    logic           d_done_q, d_done_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    cnt_inc;
    logic           timeout_hit;
    logic           pick_dcache;

`ifdef ROUND_ROBIN_EN
    // Remembers which requester was granted last; 0 means I-cache, so D-cache wins the first tie.
    logic           last_d_q, last_d_d;
    assign pick_dcache = d_req_i && (!i_req_i || !last_d_q);
`else
    assign pick_dcache = d_req_i;
`endif

    assign cnt_inc     = cnt_q + 16'd1;
    // The current BUSY cycle is the TIMEOUT_CYCLES-th one; a valid in that same cycle still wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (cnt_inc == TIMEOUT_CYCLES);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        err_d     = 1'b0;
`ifdef ROUND_ROBIN_EN
        last_d_d  = last_d_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_dcache) begin
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                    cnt_d   = 16'd0;
                    if (d_we_i) begin
                        state_d = ST_BUSY_DW;
                        wr_d    = 1'b1;
                    end else begin
                        state_d = ST_BUSY_DR;
                        rd_d    = 1'b1;
                    end
`ifdef ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                end else if (i_req_i) begin
                    addr_d  = i_addr_i;
                    cnt_d   = 16'd0;
                    state_d = ST_BUSY_I;
                    rd_d    = 1'b1;
`ifdef ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            ST_BUSY_I, ST_BUSY_DR: begin
                if (mem_read_valid_i) begin
                    if (state_q == ST_BUSY_I) begin
                        i_rdata_d = mem_rdata_i;
                        i_done_d  = 1'b1;
                    end else begin
                        d_rdata_d = mem_rdata_i;
                        d_done_d  = 1'b1;
                    end
                    rd_d    = 1'b0;
                    state_d = ST_RELEASE;
                end else if (timeout_hit) begin
                    i_done_d = (state_q == ST_BUSY_I);
                    d_done_d = (state_q == ST_BUSY_DR);
                    err_d    = 1'b1;
                    rd_d     = 1'b0;
                    state_d  = ST_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_BUSY_DW: begin
                if (mem_write_valid_i) begin
                    d_done_d = 1'b1;
                    wr_d     = 1'b0;
                    state_d  = ST_RELEASE;
                end else if (timeout_hit) begin
                    d_done_d = 1'b1;
                    err_d    = 1'b1;
                    wr_d     = 1'b0;
                    state_d  = ST_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            wdata_q   <= 256'd0;
            i_rdata_q <= 256'd0;
            d_rdata_q <= 256'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= 16'd0;
`ifdef ROUND_ROBIN_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
`ifdef ROUND_ROBIN_EN
            last_d_q  <= last_d_d;
`endif
        end
    end

    assign i_rdata_o       = i_rdata_q;
    assign i_done_o        = i_done_q;
    assign d_rdata_o       = d_rdata_q;
    assign d_done_o        = d_done_q;
    assign mem_addr_o      = addr_q;
    assign mem_wdata_o     = wdata_q;
    assign mem_blk_read_o  = rd_q;
    assign mem_blk_write_o = wr_q;
    assign xfer_err_o      = err_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Bench for mem_block_arbiter: requesters and a latency-programmable block memory are driven on the falling edge,
// and every completion is scored against a transaction-level model of ordering, data, timeout and strobe length.
module tb_mem_block_arbiter;

    localparam logic [15:0] TO  = 16'd8;
    localparam int          TOI = 8;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0]  i_addr = '0, d_addr = '0;
    logic [255:0] d_wdata = '0, mem_rdata = '0;
    logic         mem_read_valid = 1'b0, mem_write_valid = 1'b0;
    logic [255:0] i_rdata, d_rdata, mem_wdata;
    logic [31:0]  mem_addr;
    logic         i_done, d_done, mem_blk_read, mem_blk_write, xfer_err, busy;

    always #5 clk = ~clk;

    mem_block_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_done_o(i_done),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata), .d_done_o(d_done),
        .mem_addr_o(mem_addr), .mem_blk_read_o(mem_blk_read), .mem_blk_write_o(mem_blk_write),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_read_valid_i(mem_read_valid), .mem_write_valid_i(mem_write_valid),
        .xfer_err_o(xfer_err), .busy_o(busy)
    );

    typedef struct {
        bit           own_d;
        logic         err;
        bit           exp_err;
        logic [255:0] rdata;
        logic [255:0] exp_rdata;
        int           strobes;
        int           exp_strobes;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        logic         wr;
        bit           exp_wr;
        logic [255:0] wdata;
        logic [255:0] exp_wdata;
        bit           stable;
    } rec_t;

    rec_t         recs[$];
    bit           exp_own[$];
    int           n_cmp = 0, n_bad = 0;
    logic [255:0] m_i_rdata = '0, m_d_rdata = '0;
    int           lat_fixed = 2, cur_lat = 0, scyc = 0, wrong_at = 0;
    int           i_pend = 0, d_pend = 0, dbl_pulse = 0;
    bit           stable_ok = 1'b1, prev_done = 1'b0;
    bit           stray_en = 1'b0, use_a5 = 1'b0, rand_we = 1'b0;
    logic [31:0]  snap_addr = '0;
    logic [255:0] snap_wdata = '0;
    logic         snap_wr = 1'b0;

    function automatic logic [255:0] rd_data(input logic [31:0] a);
        if (use_a5) return {32{8'hA5}};
        return {a, ~a, a ^ 32'hDEAD_BEEF, a + 32'd7, {a[15:0], a[31:16]}, ~a ^ 32'h1234_5678, a - 32'd3, a ^ 32'h0F0F_F0F0};
    endfunction

    // Grant order when both requesters keep their queues non-empty from the start.
    function automatic void build_order(input int ni, input int nd);
        bit last_d = 1'b0;
        bit pick;
        exp_own.delete();
        while (ni > 0 || nd > 0) begin
            if (ni > 0 && nd > 0) pick = RR ? !last_d : 1'b1;
            else                  pick = (nd > 0);
            exp_own.push_back(pick);
            if (pick) nd--; else ni--;
            last_d = pick;
        end
    endfunction

    task automatic reset_model();
        m_i_rdata = '0; m_d_rdata = '0;
        scyc = 0; stable_ok = 1'b1; prev_done = 1'b0; cur_lat = 0;
        recs.delete();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: observe outputs, score completions into recs, then drive requesters and memory for the next edge.
    task automatic step();
        rec_t r;
        @(negedge clk);
        if (mem_blk_read || mem_blk_write) begin
            if (scyc == 0) begin
                snap_addr = mem_addr; snap_wdata = mem_wdata; snap_wr = mem_blk_write;
                cur_lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, TOI + 3));
            end else if (mem_addr !== snap_addr || mem_wdata !== snap_wdata || mem_blk_write !== snap_wr) begin
                stable_ok = 1'b0;
            end
            scyc++;
        end
        if (i_done || d_done) begin
            if (prev_done) dbl_pulse++;
            r.own_d = d_done; r.err = xfer_err; r.exp_err = (cur_lat > TOI);
            r.strobes = scyc; r.exp_strobes = (cur_lat > TOI) ? TOI : cur_lat;
            r.addr = snap_addr; r.wr = snap_wr; r.wdata = snap_wdata; r.stable = stable_ok;
            if (d_done) begin
                r.exp_addr = d_addr; r.exp_wr = d_we; r.exp_wdata = d_wdata;
                if (!d_we && !r.exp_err) m_d_rdata = rd_data(d_addr);
                r.rdata = d_rdata; r.exp_rdata = m_d_rdata;
                d_pend--;
                if (d_pend > 0) begin
                    d_addr = $urandom; d_wdata = {8{$urandom}};
                    if (rand_we) d_we = ($urandom & 1) != 0;
                end else d_req = 1'b0;
            end else begin
                r.exp_addr = i_addr; r.exp_wr = 1'b0; r.exp_wdata = '0;
                if (!r.exp_err) m_i_rdata = rd_data(i_addr);
                r.rdata = i_rdata; r.exp_rdata = m_i_rdata;
                i_pend--;
                if (i_pend > 0) i_addr = $urandom;
                else i_req = 1'b0;
            end
            recs.push_back(r);
            scyc = 0; stable_ok = 1'b1;
        end
        prev_done = i_done || d_done;
        mem_read_valid = 1'b0; mem_write_valid = 1'b0;
        mem_rdata = {8{$urandom}};
        if (mem_blk_read && scyc == cur_lat) begin
            mem_read_valid = 1'b1; mem_rdata = rd_data(mem_addr);
        end
        if (mem_blk_write && scyc == cur_lat) mem_write_valid = 1'b1;
        if (mem_blk_read && wrong_at > 0 && scyc == wrong_at) mem_write_valid = 1'b1;
        if (stray_en && !mem_blk_read && !mem_blk_write) begin
            mem_read_valid = ($urandom & 1) != 0; mem_write_valid = ($urandom & 1) != 0;
        end
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (recs.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (recs.size() >= n);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, mem_blk_read, mem_blk_write, i_done, d_done, xfer_err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl got=%b exp=000000", {busy, mem_blk_read, mem_blk_write, i_done, d_done, xfer_err});
        end
        n_cmp++;
        if (mem_addr !== 32'd0 || mem_wdata !== 256'd0) begin
            n_bad++; $display("FAIL reset_mem got addr=%h wdata=%h exp=0", mem_addr, mem_wdata);
        end
        n_cmp++;
        if (i_rdata !== 256'd0 || d_rdata !== 256'd0) begin
            n_bad++; $display("FAIL reset_rdata got i=%h d=%h exp=0", i_rdata, d_rdata);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, mem_blk_read, mem_blk_write} !== 3'b0) begin
            n_bad++; $display("FAIL reset_hold got=%b exp=000", {busy, mem_blk_read, mem_blk_write});
        end
        reset_model();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_read();
        rec_t r;
        bit ok;
        recs.delete();
        use_a5 = 1'b1; lat_fixed = 3;
        i_addr = 32'h0040_0100; i_pend = 1; i_req = 1'b1;
        run_until(1, 40, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL basic_done got=none exp=one i_done"); end
        else begin
            r = recs.pop_front();
            n_cmp++; if (r.own_d !== 1'b0) begin n_bad++; $display("FAIL basic_owner got=%0d exp=0", r.own_d); end
            n_cmp++; if (r.strobes !== r.exp_strobes) begin n_bad++; $display("FAIL basic_strobes got=%0d exp=%0d", r.strobes, r.exp_strobes); end
            n_cmp++; if (r.rdata !== r.exp_rdata) begin n_bad++; $display("FAIL basic_rdata got=%h exp=%h", r.rdata, r.exp_rdata); end
            n_cmp++; if (r.err !== r.exp_err) begin n_bad++; $display("FAIL basic_err got=%b exp=%b", r.err, r.exp_err); end
            n_cmp++; if (r.addr !== r.exp_addr) begin n_bad++; $display("FAIL basic_addr got=%h exp=%h", r.addr, r.exp_addr); end
        end
        step(); step();
        use_a5 = 1'b0; lat_fixed = 2;
    endtask

    task automatic test_min_latency();
        recs.delete();
        lat_fixed = 1; i_addr = 32'h0000_2040; i_pend = 1; i_req = 1'b1;
        step();
        n_cmp++;
        if ({mem_blk_read, busy, i_done} !== 3'b110) begin
            n_bad++; $display("FAIL minlat_strobe got rd/busy/done=%b exp=110", {mem_blk_read, busy, i_done});
        end
        step();
        n_cmp++;
        if ({mem_blk_read, busy, i_done, xfer_err} !== 4'b0110) begin
            n_bad++; $display("FAIL minlat_done got rd/busy/done/err=%b exp=0110", {mem_blk_read, busy, i_done, xfer_err});
        end
        step();
        n_cmp++;
        if ({busy, i_done} !== 2'b00) begin
            n_bad++; $display("FAIL minlat_idle got busy/done=%b exp=00", {busy, i_done});
        end
        n_cmp++;
        if (recs.size() != 1 || recs[0].rdata !== recs[0].exp_rdata) begin
            n_bad++; $display("FAIL minlat_rdata got n=%0d rdata=%h exp=%h", recs.size(), i_rdata, m_i_rdata);
        end
        step();
        lat_fixed = 2;
    endtask

    task automatic test_write();
        rec_t r;
        bit ok;
        recs.delete();
        lat_fixed = 5;
        d_we = 1'b1; d_addr = 32'h1000_0020; d_wdata = {8{$urandom}}; d_pend = 1; d_req = 1'b1;
        run_until(1, 40, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL write_done got=none exp=one d_done"); end
        else begin
            r = recs.pop_front();
            n_cmp++; if (r.own_d !== 1'b1 || r.wr !== 1'b1) begin n_bad++; $display("FAIL write_kind got own_d=%b wr=%b exp=1 1", r.own_d, r.wr); end
            n_cmp++; if (r.addr !== r.exp_addr) begin n_bad++; $display("FAIL write_addr got=%h exp=%h", r.addr, r.exp_addr); end
            n_cmp++; if (r.wdata !== r.exp_wdata) begin n_bad++; $display("FAIL write_wdata got=%h exp=%h", r.wdata, r.exp_wdata); end
            n_cmp++; if (r.strobes !== r.exp_strobes || !r.stable) begin n_bad++; $display("FAIL write_strobe got cycles=%0d stable=%0d exp=%0d 1", r.strobes, r.stable, r.exp_strobes); end
            n_cmp++; if (r.rdata !== r.exp_rdata || r.err !== 1'b0) begin n_bad++; $display("FAIL write_rdata got=%h err=%b exp=%h 0", r.rdata, r.err, r.exp_rdata); end
        end
        step(); step();
        d_we = 1'b0; lat_fixed = 2;
    endtask

    task automatic test_wrong_valid();
        rec_t r;
        bit ok;
        recs.delete();
        lat_fixed = 4; wrong_at = 2;
        i_addr = 32'h0000_8800; i_pend = 1; i_req = 1'b1;
        run_until(1, 40, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wrongvld_done got=none exp=one i_done"); end
        else begin
            r = recs.pop_front();
            n_cmp++; if (r.strobes !== r.exp_strobes) begin n_bad++; $display("FAIL wrongvld_strobes got=%0d exp=%0d", r.strobes, r.exp_strobes); end
            n_cmp++; if (r.rdata !== r.exp_rdata || r.err !== r.exp_err) begin n_bad++; $display("FAIL wrongvld_rdata got=%h err=%b exp=%h %b", r.rdata, r.err, r.exp_rdata, r.exp_err); end
        end
        step(); step();
        wrong_at = 0; lat_fixed = 2;
    endtask

    task automatic test_timeout();
        int lats[3] = '{2, 100, 8};
        rec_t r;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            recs.delete();
            lat_fixed = lats[k];
            d_we = 1'b0; d_addr = $urandom; d_pend = 1; d_req = 1'b1;
            run_until(1, 60, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL tmo_done lat=%0d got=none exp=one d_done", lats[k]); end
            else begin
                r = recs.pop_front();
                n_cmp++; if (r.err !== r.exp_err) begin n_bad++; $display("FAIL tmo_err lat=%0d got=%b exp=%b", lats[k], r.err, r.exp_err); end
                n_cmp++; if (r.strobes !== r.exp_strobes) begin n_bad++; $display("FAIL tmo_strobes lat=%0d got=%0d exp=%0d", lats[k], r.strobes, r.exp_strobes); end
                n_cmp++; if (r.rdata !== r.exp_rdata) begin n_bad++; $display("FAIL tmo_rdata lat=%0d got=%h exp=%h", lats[k], r.rdata, r.exp_rdata); end
            end
            step(); step();
        end
        lat_fixed = 2;
    endtask

    task automatic test_arbitration();
        bit ok;
        pulse_reset();
        lat_fixed = 2; d_we = 1'b0; rand_we = 1'b0;
        build_order(2, 2);
        i_addr = $urandom; d_addr = $urandom;
        i_pend = 2; d_pend = 2; i_req = 1'b1; d_req = 1'b1;
        run_until(4, 80, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL arb_count got=%0d exp=4", recs.size()); end
        for (int k = 0; k < 4 && k < recs.size(); k++) begin
            n_cmp++;
            if (recs[k].own_d !== exp_own[k]) begin
                n_bad++; $display("FAIL arb_order idx=%0d got own_d=%0d exp=%0d", k, recs[k].own_d, exp_own[k]);
            end
        end
        step(); step();
    endtask

    task automatic test_reset_midxfer();
        bit ok;
        recs.delete();
        lat_fixed = 100; d_we = 1'b0; d_addr = 32'h0000_3300; d_pend = 1; d_req = 1'b1;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_blk_read, mem_blk_write, busy} !== 3'b000) begin
            n_bad++; $display("FAIL rstmid_async got rd/wr/busy=%b exp=000", {mem_blk_read, mem_blk_write, busy});
        end
        reset_model();
        lat_fixed = 2;
        repeat (3) step();
        n_cmp++;
        if (recs.size() != 0) begin n_bad++; $display("FAIL rstmid_nodone got=%0d done pulses exp=0", recs.size()); end
        rst_n = 1'b1;
        run_until(1, 40, ok);
        n_cmp++;
        if (!ok || recs[0].own_d !== 1'b1 || recs[0].err !== 1'b0 || recs[0].rdata !== recs[0].exp_rdata) begin
            n_bad++; $display("FAIL rstmid_retry got n=%0d d_rdata=%h exp one D read %h", recs.size(), d_rdata, m_d_rdata);
        end
        step(); step();
    endtask

    task automatic test_random();
        rec_t r;
        bit ok;
        int ni, nd;
        for (int round = 0; round < 4; round++) begin
            pulse_reset();
            stray_en = 1'b1; rand_we = 1'b1; lat_fixed = 0;
            ni = $urandom_range(1, 4); nd = $urandom_range(1, 4);
            build_order(ni, nd);
            i_addr = $urandom; d_addr = $urandom; d_wdata = {8{$urandom}}; d_we = ($urandom & 1) != 0;
            i_pend = ni; d_pend = nd; i_req = 1'b1; d_req = 1'b1;
            run_until(ni + nd, 600, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL rnd_count round=%0d got=%0d exp=%0d", round, recs.size(), ni + nd); end
            for (int k = 0; k < ni + nd; k++) begin
                if (recs.size() == 0) break;
                r = recs.pop_front();
                n_cmp++; if (r.own_d !== exp_own[k]) begin n_bad++; $display("FAIL rnd_owner r=%0d i=%0d got=%0d exp=%0d", round, k, r.own_d, exp_own[k]); end
                n_cmp++; if (r.err !== r.exp_err) begin n_bad++; $display("FAIL rnd_err r=%0d i=%0d got=%b exp=%b", round, k, r.err, r.exp_err); end
                n_cmp++; if (r.rdata !== r.exp_rdata) begin n_bad++; $display("FAIL rnd_rdata r=%0d i=%0d got=%h exp=%h", round, k, r.rdata, r.exp_rdata); end
                n_cmp++; if (r.strobes !== r.exp_strobes) begin n_bad++; $display("FAIL rnd_strobes r=%0d i=%0d got=%0d exp=%0d", round, k, r.strobes, r.exp_strobes); end
                n_cmp++; if (r.addr !== r.exp_addr || r.wr !== r.exp_wr || !r.stable) begin n_bad++; $display("FAIL rnd_cmd r=%0d i=%0d got addr=%h wr=%b stable=%0d exp=%h %b 1", round, k, r.addr, r.wr, r.stable, r.exp_addr, r.exp_wr); end
                if (r.exp_wr) begin
                    n_cmp++; if (r.wdata !== r.exp_wdata) begin n_bad++; $display("FAIL rnd_wdata r=%0d i=%0d got=%h exp=%h", round, k, r.wdata, r.exp_wdata); end
                end
            end
            stray_en = 1'b0;
            step(); step();
        end
        rand_we = 1'b0; d_we = 1'b0; lat_fixed = 2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_read();
        test_min_latency();
        test_write();
        test_wrong_valid();
        test_timeout();
        test_arbitration();
        test_reset_midxfer();
        test_random();
        n_cmp++;
        if (dbl_pulse != 0) begin n_bad++; $display("FAIL done_width got=%0d back-to-back done pulses exp=0", dbl_pulse); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
